// File: rtl/fir_uart_controller_if.sv
// rtl/fir_uart_controller_if.sv - control strobe bundle between UART/FIR datapath and its controller
interface fir_uart_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 RxD_data_ready;
    logic                 output_valid;
    logic                 TxD_busy;
    logic                 Load_FIR_In_LSB;
    logic                 Load_FIR_In_MSB;
    logic                 input_valid;
    logic                 Load_FIR_OUT;
    logic                 TxD_start;
    logic                 TxD_data_select;
    logic                 ctrl_busy;
    logic [CNT_WIDTH-1:0] sample_count;
    logic                 rx_overrun;
    logic                 timeout_err;

    // Controller side: consumes status pulses, drives strobes and status
    modport master (
        input  RxD_data_ready, output_valid, TxD_busy,
        output Load_FIR_In_LSB, Load_FIR_In_MSB, input_valid, Load_FIR_OUT,
        output TxD_start, TxD_data_select, ctrl_busy, sample_count,
        output rx_overrun, timeout_err
    );

    // Datapath side: produces status pulses, obeys strobes
    modport slave (
        output RxD_data_ready, output_valid, TxD_busy,
        input  Load_FIR_In_LSB, Load_FIR_In_MSB, input_valid, Load_FIR_OUT,
        input  TxD_start, TxD_data_select, ctrl_busy, sample_count,
        input  rx_overrun, timeout_err
    );
endinterface

// File: rtl/fir_uart_controller.sv
// rtl/fir_uart_controller.sv - UART-fed FIR control FSM; optional FIR wait timeout via FIR_CTRL_TIMEOUT_EN
module fir_uart_controller #(
    parameter int CNT_WIDTH = 16
`ifdef FIR_CTRL_TIMEOUT_EN
    , parameter int FIR_TIMEOUT = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_uart_controller_if.master bus
);
    typedef enum logic [3:0] {
        WAIT_LSB, LOAD_LSB, WAIT_MSB, LOAD_MSB, FIR_GO, FIR_WAIT,
        CAPTURE, SEND_LSB, TXW_LSB, SEND_MSB, TXW_MSB
    } state_t;

    state_t               state, next_state;
    logic                 seen_busy;
    logic                 count_inc;
    logic                 overrun_set;
    logic                 timeout_hit;
    logic                 load_lsb_q, load_msb_q, input_valid_q, load_out_q;
    logic                 tx_start_q, tx_select_q, ctrl_busy_q;
    logic                 rx_overrun_q;
    logic [CNT_WIDTH-1:0] sample_count_q;

`ifdef FIR_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(FIR_TIMEOUT) + 1;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_err_q;
`endif

    // Next-state decode; a byte arriving outside the two receive states is dropped and flagged
    always_comb begin
        next_state  = state;
        count_inc   = 1'b0;
        timeout_hit = 1'b0;
        overrun_set = bus.RxD_data_ready && (state != WAIT_LSB) && (state != WAIT_MSB);
        case (state)
            WAIT_LSB: if (bus.RxD_data_ready) next_state = LOAD_LSB;
            LOAD_LSB: next_state = WAIT_MSB;
            WAIT_MSB: if (bus.RxD_data_ready) next_state = LOAD_MSB;
            LOAD_MSB: next_state = FIR_GO;
            FIR_GO:   next_state = FIR_WAIT;
            FIR_WAIT: begin
                if (bus.output_valid) begin
                    next_state = CAPTURE;
                end
`ifdef FIR_CTRL_TIMEOUT_EN
                else if (tmo_cnt == TW'(FIR_TIMEOUT - 1)) begin
                    next_state  = WAIT_LSB;
                    timeout_hit = 1'b1;
                end
`endif
            end
            CAPTURE:  next_state = SEND_LSB;
            SEND_LSB: if (!bus.TxD_busy) next_state = TXW_LSB;
            TXW_LSB:  if (seen_busy && !bus.TxD_busy) next_state = SEND_MSB;
            SEND_MSB: if (!bus.TxD_busy) next_state = TXW_MSB;
            TXW_MSB: begin
                if (seen_busy && !bus.TxD_busy) begin
                    next_state = WAIT_LSB;
                    count_inc  = 1'b1;
                end
            end
            default:  next_state = WAIT_LSB;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_LSB;
        else        state <= next_state;
    end

    // Remember that the UART went busy after our start, so only the falling edge ends the wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) seen_busy <= 1'b0;
        else if ((state == TXW_LSB || state == TXW_MSB) && next_state == state)
            seen_busy <= seen_busy | bus.TxD_busy;
        else
            seen_busy <= 1'b0;
    end

    // Registered strobes decoded from the next state, so each one is high exactly while in its state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_lsb_q     <= 1'b0;
            load_msb_q     <= 1'b0;
            input_valid_q  <= 1'b0;
            load_out_q     <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_select_q    <= 1'b0;
            ctrl_busy_q    <= 1'b0;
            rx_overrun_q   <= 1'b0;
            sample_count_q <= '0;
        end else begin
            load_lsb_q    <= (next_state == LOAD_LSB);
            load_msb_q    <= (next_state == LOAD_MSB);
            input_valid_q <= (next_state == FIR_GO);
            load_out_q    <= (next_state == CAPTURE);
            tx_start_q    <= (state == SEND_LSB && next_state == TXW_LSB) ||
                             (state == SEND_MSB && next_state == TXW_MSB);
            ctrl_busy_q   <= (next_state != WAIT_LSB);
            if (next_state == SEND_LSB)      tx_select_q <= 1'b0;
            else if (next_state == SEND_MSB) tx_select_q <= 1'b1;
            if (overrun_set) rx_overrun_q <= 1'b1;
            if (count_inc)   sample_count_q <= sample_count_q + 1'b1;
        end
    end

`ifdef FIR_CTRL_TIMEOUT_EN
    // Cycle counter for the FIR wait; sticky error once it expires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state == FIR_WAIT && next_state == FIR_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            else                                             tmo_cnt <= '0;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.Load_FIR_In_LSB = load_lsb_q;
    assign bus.Load_FIR_In_MSB = load_msb_q;
    assign bus.input_valid     = input_valid_q;
    assign bus.Load_FIR_OUT    = load_out_q;
    assign bus.TxD_start       = tx_start_q;
    assign bus.TxD_data_select = tx_select_q;
    assign bus.ctrl_busy       = ctrl_busy_q;
    assign bus.rx_overrun      = rx_overrun_q;
    assign bus.sample_count    = sample_count_q;
endmodule

// File: tb/tb_fir_uart_controller.sv
// tb/tb_fir_uart_controller.sv - directed self-checking bench for fir_uart_controller
module tb_fir_uart_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_lsb = 0, n_msb = 0, n_iv = 0, n_out = 0, n_start = 0, n_bad_start = 0;

    fir_uart_controller_if #(.CNT_WIDTH(16)) bus ();

`ifdef FIR_CTRL_TIMEOUT_EN
    fir_uart_controller #(.CNT_WIDTH(16), .FIR_TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    fir_uart_controller #(.CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Pulse counters observed away from the rising edge
    always @(negedge clk) begin
        if (bus.Load_FIR_In_LSB) n_lsb++;
        if (bus.Load_FIR_In_MSB) n_msb++;
        if (bus.input_valid)     n_iv++;
        if (bus.Load_FIR_OUT)    n_out++;
        if (bus.TxD_start) begin
            n_start++;
            if (bus.TxD_busy) n_bad_start++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte();
        bus.RxD_data_ready = 1'b1;
        cyc(1);
        bus.RxD_data_ready = 1'b0;
        cyc(3);
    endtask

    task automatic fir_done(input int delay);
        cyc(delay);
        bus.output_valid = 1'b1;
        cyc(1);
        bus.output_valid = 1'b0;
    endtask

    // Wait for one TxD_start, check the byte select, then emulate the UART being busy
    task automatic tx_byte(input string tag, input logic exp_sel, input int busy_cycles);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus.TxD_start) found = 1'b1;
        end
        check({tag, "_start_seen"}, 32'(found), 32'd1);
        check({tag, "_select"}, 32'(bus.TxD_data_select), 32'(exp_sel));
        @(posedge clk);
        #1;
        bus.TxD_busy = 1'b1;
        cyc(busy_cycles);
        check({tag, "_select_stable"}, 32'(bus.TxD_data_select), 32'(exp_sel));
        bus.TxD_busy = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_lsb"},   32'(bus.Load_FIR_In_LSB), 32'd0);
        check({tag, "_msb"},   32'(bus.Load_FIR_In_MSB), 32'd0);
        check({tag, "_iv"},    32'(bus.input_valid),     32'd0);
        check({tag, "_out"},   32'(bus.Load_FIR_OUT),    32'd0);
        check({tag, "_start"}, 32'(bus.TxD_start),       32'd0);
        check({tag, "_sel"},   32'(bus.TxD_data_select), 32'd0);
        check({tag, "_busy"},  32'(bus.ctrl_busy),       32'd0);
        check({tag, "_count"}, 32'(bus.sample_count),    32'd0);
    endtask

    initial begin
        int b_lsb, b_msb, b_iv, b_out, b_start;

        // Reset held with inputs toggling
        bus.RxD_data_ready = 1'b0;
        bus.output_valid   = 1'b0;
        bus.TxD_busy       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.RxD_data_ready = i[0];
            bus.output_valid   = ~i[0];
            bus.TxD_busy       = i[1];
            cyc(1);
        end
        check_idle_outputs("reset");
        check("reset_overrun", 32'(bus.rx_overrun), 32'd0);
        check("reset_timeout", 32'(bus.timeout_err), 32'd0);
        bus.RxD_data_ready = 1'b0;
        bus.output_valid   = 1'b0;
        bus.TxD_busy       = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // Frame 1: bytes 0x34, 0x12, FIR result 70 cycles later
        send_byte();
        check("f1_lsb_load", 32'(n_lsb), 32'd1);
        check("f1_lsb_no_msb", 32'(n_msb), 32'd0);
        check("f1_busy", 32'(bus.ctrl_busy), 32'd1);
        send_byte();
        check("f1_msb_load", 32'(n_msb), 32'd1);
        check("f1_input_valid", 32'(n_iv), 32'd1);
        fir_done(70);
        cyc(1);
        check("f1_load_out", 32'(n_out), 32'd1);
        tx_byte("f1_tx0", 1'b0, 5);
        tx_byte("f1_tx1", 1'b1, 5);
        cyc(3);
        check("f1_starts", 32'(n_start), 32'd2);
        check("f1_count", 32'(bus.sample_count), 32'd1);
        check("f1_idle", 32'(bus.ctrl_busy), 32'd0);
        check("f1_overrun", 32'(bus.rx_overrun), 32'd0);
        check("f1_iv_once", 32'(n_iv), 32'd1);

        // Frame 2: UART stays busy for 200 cycles while in SEND_LSB
        send_byte();
        send_byte();
        bus.TxD_busy = 1'b1;
        fir_done(5);
        b_start = n_start;
        cyc(200);
        check("busy_no_start", 32'(n_start), 32'(b_start));
        bus.TxD_busy = 1'b0;
        tx_byte("f2_tx0", 1'b0, 4);
        check("busy_one_start", 32'(n_start), 32'(b_start + 1));
        tx_byte("f2_tx1", 1'b1, 4);
        cyc(3);
        check("f2_count", 32'(bus.sample_count), 32'd2);

        // Frame 3: stray byte while waiting for the FIR
        send_byte();
        send_byte();
        b_out = n_out;
        b_lsb = n_lsb;
        cyc(10);
        bus.RxD_data_ready = 1'b1;
        cyc(1);
        bus.RxD_data_ready = 1'b0;
        cyc(2);
        check("ovr_flag", 32'(bus.rx_overrun), 32'd1);
        check("ovr_still_busy", 32'(bus.ctrl_busy), 32'd1);
        check("ovr_no_capture", 32'(n_out), 32'(b_out));
        check("ovr_no_lsb", 32'(n_lsb), 32'(b_lsb));
        fir_done(3);
        tx_byte("f3_tx0", 1'b0, 3);
        tx_byte("f3_tx1", 1'b1, 3);
        cyc(3);
        check("f3_count", 32'(bus.sample_count), 32'd3);

        // Frame 4: starts at LSB; stray output_valid in WAIT_MSB is ignored
        b_lsb = n_lsb;
        b_msb = n_msb;
        b_out = n_out;
        b_iv  = n_iv;
        send_byte();
        check("f4_lsb", 32'(n_lsb), 32'(b_lsb + 1));
        check("f4_no_msb", 32'(n_msb), 32'(b_msb));
        fir_done(1);
        cyc(2);
        check("f4_ov_ignored", 32'(n_out), 32'(b_out));
        check("f4_ov_no_iv", 32'(n_iv), 32'(b_iv));
        send_byte();
        check("f4_msb", 32'(n_msb), 32'(b_msb + 1));
        fir_done(4);
        tx_byte("f4_tx0", 1'b0, 2);
        tx_byte("f4_tx1", 1'b1, 2);
        cyc(3);
        check("f4_count", 32'(bus.sample_count), 32'd4);
        check("overrun_sticky", 32'(bus.rx_overrun), 32'd1);

        // Frame 5: reset pulse while in TXW_MSB
        send_byte();
        send_byte();
        fir_done(2);
        tx_byte("f5_tx0", 1'b0, 3);
        tx_byte("f5_tx1", 1'b1, 1);
        bus.TxD_busy = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        check_idle_outputs("midreset");
        check("midreset_overrun", 32'(bus.rx_overrun), 32'd0);
        reset = 1'b1;
        bus.TxD_busy = 1'b0;
        cyc(2);
        send_byte();
        send_byte();
        fir_done(6);
        tx_byte("f6_tx0", 1'b0, 3);
        tx_byte("f6_tx1", 1'b1, 3);
        cyc(3);
        check("f6_count", 32'(bus.sample_count), 32'd1);
        check("f6_idle", 32'(bus.ctrl_busy), 32'd0);

`ifdef FIR_CTRL_TIMEOUT_EN
        // Frame 7: FIR never answers
        send_byte();
        send_byte();
        b_start = n_start;
        cyc(25);
        check("tmo_flag", 32'(bus.timeout_err), 32'd1);
        check("tmo_idle", 32'(bus.ctrl_busy), 32'd0);
        check("tmo_no_tx", 32'(n_start), 32'(b_start));
        check("tmo_count", 32'(bus.sample_count), 32'd1);
`else
        check("no_timeout", 32'(bus.timeout_err), 32'd0);
`endif
        check("never_start_while_busy", 32'(n_bad_start), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
